// File: rtl/addsub_scheduler_pkg.sv
// Shared state encoding, operation codes and sizing helper for the
// round-robin add/subtract scheduler.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Width of a requester index; never below one bit.
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/addsub_scheduler_if.sv
// Request, response and adder channels of the scheduler; the scheduler
// takes the slave view, requesters plus the external adder take the master view.
interface addsub_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 64
);
  import addsub_pkg::*;

  localparam int IW = id_width(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_p;
  logic [NREQ*WIDTH-1:0] req_q;
  logic [NREQ-1:0]       req_cin;
  logic [NREQ-1:0]       req_op;

  logic [WIDTH-1:0]      add_p;
  logic [WIDTH-1:0]      add_q;
  logic                  add_cin;
  logic                  add_op;
  logic [WIDTH-1:0]      add_result;
  logic                  add_carry;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IW-1:0]         rsp_id;
  logic [WIDTH-1:0]      rsp_result;
  logic                  rsp_carry;

  modport master (
    output req_valid, req_p, req_q, req_cin, req_op, rsp_ready,
           add_result, add_carry,
    input  req_ready, add_p, add_q, add_cin, add_op,
           rsp_valid, rsp_id, rsp_result, rsp_carry
  );

  modport slave (
    input  req_valid, req_p, req_q, req_cin, req_op, rsp_ready,
           add_result, add_carry,
    output req_ready, add_p, add_q, add_cin, add_op,
           rsp_valid, rsp_id, rsp_result, rsp_carry
  );

endinterface

// File: rtl/addsub_scheduler_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above
// rr_ptr, wrapping around, as a one-hot grant plus its encoded index.
module rr_pick
  import addsub_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IW-1:0]   rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   winner
);

  int          idx;
  logic [IW-1:0] sel;
  logic        found;

  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    sel    = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(rr_ptr) + i) % NREQ;
      sel = IW'(idx);
      if (!found && req_valid[sel]) begin
        found      = 1'b1;
        grant[sel] = 1'b1;
        winner     = sel;
      end
    end
  end

endmodule

// File: rtl/addsub_scheduler.sv
// Shares one external add/subtract unit among NREQ requesters, one
// operation in flight, round-robin arbitration and a held response channel.
module addsub_scheduler
#(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 64,
  parameter int ADDER_LAT = 1
) (
  input logic              clk,
  input logic              rst_n,
  addsub_scheduler_if.slave bus
);
  import addsub_pkg::*;

  localparam int IW = id_width(NREQ);
  localparam int CW = (ADDER_LAT < 1) ? 1 : $clog2(ADDER_LAT + 1);

  state_t           state, state_nxt;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    winner;
  logic [NREQ-1:0]  grant;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] op_p, op_q;
  logic             op_cin, op_op;
  logic [IW-1:0]    op_id;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic             any_req;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req_valid(bus.req_valid),
    .rr_ptr   (rr_ptr),
    .grant    (grant),
    .winner   (winner)
  );

  assign any_req = |bus.req_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req)          state_nxt = BUSY;
      BUSY:    if (cnt == '0)        state_nxt = RESP;
      RESP:    if (bus.rsp_ready)    state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  // Grants are masked while reset is asserted so nothing is accepted then.
  assign bus.req_ready  = (state == IDLE && rst_n) ? grant : '0;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_id     = op_id;
  assign bus.rsp_result = res_q;
  assign bus.rsp_carry  = carry_q;
  assign bus.add_p      = op_p;
  assign bus.add_q      = op_q;
  assign bus.add_cin    = op_cin;
  assign bus.add_op     = op_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      cnt     <= '0;
      op_p    <= '0;
      op_q    <= '0;
      op_cin  <= 1'b0;
      op_op   <= 1'b0;
      op_id   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          op_p   <= bus.req_p[winner*WIDTH +: WIDTH];
          op_q   <= bus.req_q[winner*WIDTH +: WIDTH];
          op_cin <= bus.req_cin[winner];
          op_op  <= bus.req_op[winner];
          op_id  <= winner;
          cnt    <= CW'(ADDER_LAT);
          rr_ptr <= (winner == IW'(NREQ - 1)) ? '0 : winner + IW'(1);
        end
        BUSY: if (cnt != '0) begin
          cnt <= cnt - CW'(1);
        end else begin
          res_q   <= bus.add_result;
          carry_q <= bus.add_carry;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/addsub_scheduler.md
# addsub_scheduler

Round-robin scheduler that shares one `fast_adder` 64-bit add/subtract unit among `NREQ` requesters. Each requester submits an operand pair, a carry-in and an operation over a valid/ready handshake. The scheduler grants one requester and sequences the operation through the adder. It returns the result, carry and requester id over a single valid/ready response channel. One operation is in flight at a time, and the scheduler sits directly in front of the adder instance.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `WIDTH`, 64: operand and result width. Must match the `fast_adder` width.
- `ADDER_LAT`, 1: number of clock edges from `add_*` inputs being sampled to `add_result`/`add_carry` being valid.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NREQ: per-requester request valid.
- `req_ready` out NREQ: per-requester accept. At most one bit is high.
- `req_p` in NREQ*WIDTH: flattened operand p. Requester i occupies bits [i*WIDTH +: WIDTH].
- `req_q` in NREQ*WIDTH: flattened operand q, same packing as `req_p`.
- `req_cin` in NREQ: carry-in.
- `req_op` in NREQ: 0 = add, 1 = subtract.
- `add_p`, `add_q` out WIDTH each: operands to the adder.
- `add_cin`, `add_op` out 1 each: carry-in and operation to the adder.
- `add_result` in WIDTH: adder result.
- `add_carry` in 1: adder carry-out.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response accept.
- `rsp_id` out clog2(NREQ): index of the requester that owns the response.
- `rsp_result` out WIDTH: registered `add_result`.
- `rsp_carry` out 1: registered `add_carry`.

## Operation
- FSM states and transitions:
  - IDLE -> BUSY when any `req_valid` is high.
  - BUSY -> RESP when the wait counter is 0.
  - RESP -> IDLE on `rsp_valid & rsp_ready`.
- IDLE:
  - The winner is the first `req_valid` bit found searching upward from `rr_ptr`, wrapping around.
  - `req_ready[winner]` is driven combinationally in that same cycle.
  - On the edge, the scheduler captures p, q, cin, op and id into operand registers and loads `cnt = ADDER_LAT`.
  - `rr_ptr` is set to (winner+1) mod NREQ.
- BUSY:
  - `add_*` outputs are driven from the operand registers and stay stable for the whole state.
  - If `cnt != 0`, then `cnt--`.
  - If `cnt == 0`, the scheduler captures `add_result`/`add_carry` into `rsp_result`/`rsp_carry` and moves to RESP.
- RESP:
  - `rsp_valid` is high. All response outputs are held until `rsp_ready` is sampled high.
- `req_ready` is all-zero in BUSY and RESP. Requests arriving in those states wait.
- Requesters must hold their payload stable while `req_valid` is high. Dropping `req_valid` before it is granted is legal and simply forfeits the turn.
- Arithmetic is the adder's, passed through unmodified; the scheduler performs no arithmetic on the data:
  - `rsp_result` is WIDTH bits; any overflow appears only as `rsp_carry`.
  - Subtract is p + ~q + 1 with `cin` ignored by the adder. `carry` = 1 means no borrow.
- Reset, whether at power-up or mid-operation:
  - The in-flight operation is discarded and no response is emitted.
  - `rr_ptr` returns to 0 and the state returns to IDLE.

## Timing
- Reset values: `req_ready` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_result` = 0, `rsp_carry` = 0, `add_p` = 0, `add_q` = 0, `add_cin` = 0, `add_op` = 0.
- The request is accepted on edge k.
- `add_*` are valid from edge k.
- `rsp_valid` rises after edge k+ADDER_LAT+1. This is 2 cycles when ADDER_LAT = 1.
- The response is accepted on the first edge where `rsp_valid & rsp_ready` are both high. The earliest next grant is the following cycle.
- Back-to-back throughput is one operation per ADDER_LAT+3 cycles.
- When several requesters are valid simultaneously, the `rr_ptr` order decides the winner. A requester that stays valid waits at most NREQ-1 grants.

## Structure
- Package `addsub_pkg` holds:
  - state encoding IDLE/BUSY/RESP;
  - `OP_ADD` = 0, `OP_SUB` = 1;
  - the id-width function clog2(NREQ).
- Sub-module `rr_pick` (combinational): inputs `req_valid` and `rr_ptr`; outputs one-hot grant and encoded winner index.
- The `fast_adder` instance lives outside the scheduler and is connected only via the `add_*` ports.

## Test plan
- **Single add:** requester 0 sends p=0x1111, q=0x0101, cin=0, op=add. Expect `rsp_result` = 0x1212, `rsp_carry` = 0, `rsp_id` = 0, with `rsp_valid` exactly 2 cycles after accept.
- **Subtract:** requester 2 sends p=0x1111, q=0x0101, op=sub. Expect `rsp_result` = 0x1010, `rsp_carry` = 1, `rsp_id` = 2.
- **Overflow:** p=0xFFFF_FFFF_FFFF_FFFF, q=1, cin=0, add. Expect `rsp_result` = 0, `rsp_carry` = 1.
- **Fairness:** all 4 requesters hold `req_valid` continuously. Expect grants in the order 0,1,2,3,0, with `req_ready` one-hot and never asserted outside IDLE.
- **Backpressure:** `rsp_ready` is held low for 5 cycles. Expect `rsp_*` stable throughout, no new grant, and completion on the cycle `rsp_ready` rises.
- **Reset mid-operation:** `rst_n` is pulled low during BUSY. Expect all outputs to be 0 immediately, and the next request to be granted from `rr_ptr` = 0.
